// File: rtl/clk_div_n.sv
// Programmable integer clock divider with 50% duty for odd and even N.
// A new divisor becomes pending on load and takes effect only at the period wrap.
module clk_div_n #(
    parameter int DIV_W    = 8,
    parameter int DIV_INIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             period_start,
    output logic             load_ack,
    output logic             load_err,
    output logic [DIV_W-1:0] div_cur
);

    localparam logic [DIV_W-1:0] N_INIT = DIV_W'(DIV_INIT);

    logic [DIV_W-1:0] cnt, cnt_nxt, n_nxt, pend_val;
    logic             pend_vld, pos_q, neg_q, odd_q, wrap, load_ok;

    assign wrap    = (cnt == div_cur - DIV_W'(1));
    assign load_ok = div_load && (div_val >= DIV_W'(2));

    always_comb begin
        cnt_nxt = wrap ? '0 : cnt + DIV_W'(1);
        n_nxt   = (wrap && pend_vld) ? pend_val : div_cur;
    end

    // Reset parks cnt at N-1 so the first edge after release is a wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= N_INIT - DIV_W'(1);
            div_cur      <= N_INIT;
            pend_val     <= N_INIT;
            pend_vld     <= 1'b0;
            pos_q        <= 1'b0;
            odd_q        <= N_INIT[0];
            period_start <= 1'b0;
            load_ack     <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            div_cur      <= n_nxt;
            pos_q        <= (cnt_nxt < (n_nxt >> 1));
            odd_q        <= n_nxt[0];
            period_start <= wrap;
            load_ack     <= wrap && pend_vld;
            load_err     <= div_load && !load_ok;
            // A load sampled on the wrap edge itself survives into the next period.
            if (load_ok) begin
                pend_val <= div_val;
                pend_vld <= 1'b1;
            end else if (wrap) begin
                pend_vld <= 1'b0;
            end
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) neg_q <= 1'b0;
        else      neg_q <= pos_q;
    end

    // neg_q is always low at the wrap edge, so odd_q switching there cannot glitch.
    assign clk_out = pos_q | (odd_q & neg_q);

endmodule

// File: doc/clk_div_n.md
CLK_DIV_N -- requirements
Module: clk_div_n

Interface
REQ-001 SHALL provide parameter DIV_W, default 8, meaning width of all divisor values.
REQ-002 SHALL provide parameter DIV_INIT, default 3, meaning the divisor loaded at reset; legal range 2..2^DIV_W-1.
REQ-003 SHALL provide port clk, input, 1, the single clock; all state is clocked by it on posedge, except the one negedge flop defined in REQ-013.
REQ-004 SHALL provide port rst, input, 1, reset: asynchronous assertion, active-low.
REQ-005 SHALL provide port div_val, input, DIV_W, the requested divisor, sampled only when div_load=1.
REQ-006 SHALL provide port div_load, input, 1, a request to load div_val as the pending divisor.
REQ-007 SHALL provide port clk_out, output, 1, the divided clock with 50% duty for both odd and even N.
REQ-008 SHALL provide port period_start, output, 1, a one-cycle pulse in every clk cycle where clk_out rises.
REQ-009 SHALL provide port load_ack, output, 1, a one-cycle pulse in the cycle where a pending divisor takes effect.
REQ-010 SHALL provide port load_err, output, 1, a one-cycle pulse when div_load carries an illegal div_val (0 or 1).
REQ-011 SHALL provide port div_cur, output, DIV_W, the divisor N currently in effect.

Function
REQ-012 SHALL run a counter cnt over 0..N-1, advancing each posedge and wrapping to 0 after N-1; clk_out period = exactly N clk periods.
REQ-013 SHALL drive posedge flop pos_q=1 when cnt < floor(N/2); negedge flop neg_q samples pos_q.
REQ-014 SHALL drive clk_out: even N -> pos_q; odd N -> pos_q OR neg_q; high time = N/2 clk periods (N=3: 15 ns high, 15 ns low at 10 ns clk).
REQ-015 SHALL make the clk_out rise coincide with the posedge where cnt becomes 0; clk_out SHALL be glitch-free, including across divisor changes.
REQ-016 SHALL assert period_start in the cycle where cnt==0.
REQ-017 SHALL latch a legal div_val (>=2) into a pending register with a valid flag when div_load=1; a later load before application overwrites it (last wins).
REQ-018 SHALL apply the pending divisor only at the wrap posedge (cnt N-1 -> 0): the new N governs the period starting at that edge; load_ack pulses in that cycle; the pending flag clears.
REQ-019 SHALL treat a div_load sampled at the wrap edge itself as pending for the following wrap; it SHALL NOT affect the period just starting.
REQ-020 SHALL, on div_load with div_val<2, pulse load_err for one cycle and leave the pending register, flag and N unchanged.
REQ-021 SHALL treat a reload of the value equal to the current N as a normal load, including its load_ack pulse.
REQ-022 SHALL NOT shorten or truncate an in-progress period on any load.

Reset
REQ-023 SHALL, while rst=0, force clk_out=0, pos_q=0, neg_q=0, period_start=0, load_ack=0, load_err=0, pending flag=0 and div_cur=DIV_INIT, asynchronously.
REQ-024 SHALL hold cnt at N-1 in reset, so the first posedge after rst rises yields cnt=0 and the first clk_out rise.
REQ-025 SHALL, when rst asserts mid-period, drop clk_out to 0 immediately and discard any pending divisor.

Verification (clk period 10 ns)
REQ-026 SHALL check reset release with DIV_INIT=3 -> clk_out first rises at the first posedge after rst rises; period 30 ns; 15 ns high; period_start every 3rd cycle.
REQ-027 SHALL check div_load=1 with div_val=4 mid-period at N=3 -> the current 30 ns period completes; load_ack pulses at the wrap; the following period is 40 ns with 20 ns high; div_cur=4.
REQ-028 SHALL check div_load of 5 then 7 within one period -> only 7 is applied at the wrap (70 ns period, 35 ns high); a single load_ack.
REQ-029 SHALL check div_load with div_val=1, then 0 -> two load_err pulses; N, period and pending state unchanged; no load_ack.
REQ-030 SHALL check rst pulsed low during a clk_out high phase at N=5 -> clk_out goes 0 without waiting for clk; after release, N=DIV_INIT and the first rise is at the first posedge.
REQ-031 SHALL check div_val=255 with DIV_W=8 -> period 2550 ns, 1275 ns high, no glitches on clk_out across the 3->255->2 transitions.
